// File: rtl/alu_pkg.sv
// Shared types for the ALU/MDU slice: operation codes, branch selector encoding,
// FSM states and the bounds of the M-extension op range.
package alu_pkg;

  localparam int OP_M_FIRST = 32;
  localparam int OP_M_LAST  = 39;

  typedef enum logic [5:0] {
    OP_NONE   = 6'd0,
    OP_ADD    = 6'd1,  OP_SUB    = 6'd2,  OP_AND    = 6'd3,  OP_OR     = 6'd4,
    OP_XOR    = 6'd5,  OP_SLT    = 6'd6,  OP_SLTU   = 6'd7,  OP_SRA    = 6'd8,
    OP_SRL    = 6'd9,  OP_SLL    = 6'd10,
    OP_ADDI   = 6'd11, OP_ANDI   = 6'd12, OP_ORI    = 6'd13, OP_XORI   = 6'd14,
    OP_SLTI   = 6'd15, OP_SLTIU  = 6'd16, OP_SRAI   = 6'd17, OP_SRLI   = 6'd18,
    OP_SLLI   = 6'd19, OP_LUI    = 6'd20,
    OP_LW     = 6'd21, OP_SW     = 6'd22,
    OP_BEQ    = 6'd23, OP_BNE    = 6'd24, OP_BLT    = 6'd25, OP_BGT    = 6'd26,
    OP_BLTU   = 6'd27, OP_BGEU   = 6'd28,
    OP_AUIPC  = 6'd29, OP_JAL    = 6'd30, OP_JALR   = 6'd31,
    OP_MUL    = 6'd32, OP_MULH   = 6'd33, OP_MULHSU = 6'd34, OP_MULHU  = 6'd35,
    OP_DIV    = 6'd36, OP_DIVU   = 6'd37, OP_REM    = 6'd38, OP_REMU   = 6'd39
  } op_e;

  typedef enum logic [1:0] {
    BR_NONE      = 2'b00,
    BR_NOT_TAKEN = 2'b01,
    BR_TAKEN     = 2'b10
  } branch_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes with a
// combinational sign fix-up. Only built when ALU_MDU_M_EN is defined.
`ifdef ALU_MDU_M_EN
module alu_mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res
);

  // sel: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  assign a_signed = (sel == 3'd1) || (sel == 3'd2) || (sel == 3'd4) || (sel == 3'd6);
  assign b_signed = (sel == 3'd1) || (sel == 3'd4) || (sel == 3'd6);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign mag_a    = a_neg ? -a : a;
  assign mag_b    = b_neg ? -b : b;

  // hi: running partial product / remainder; lo: multiplier / quotient
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [2:0]      sel_q;
  logic            a_neg_q, b_neg_q, b_zero_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      sel_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= mag_a;
      opnd_q   <= mag_b;
      sel_q    <= sel;
      a_neg_q  <= a_neg;
      b_neg_q  <= b_neg;
      b_zero_q <= (b == '0);
    end else if (step) begin
      if (!sel_q[2]) begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN+1]) begin
        hi_q <= div_diff[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_q <= div_shift[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
  // Divide by zero keeps the all-ones quotient; the remainder naturally restores the dividend.
  assign quo_fix  = b_zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -lo_q : lo_q);
  assign rem_fix  = a_neg_q ? -hi_q : hi_q;

  always_comb begin
    res = rem_fix;
    case (sel_q)
      3'd0:                res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res = quo_fix;
      default:             res = rem_fix;
    endcase
  end

endmodule
`endif

// File: rtl/alu_mdu_unit.sv
// ALU with an optional iterative multiply/divide unit behind a valid/ready handshake.
// Define ALU_MDU_M_EN to implement ops 32-39; otherwise they complete as illegal.
module alu_mdu_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      branch_sel,
  output logic            illegal,
  output state_e          dbg_state
);

  // Handshake: an op transfers on a clk edge with in_valid & in_ready (IDLE only);
  // a result transfers on an edge with out_valid & out_ready, and until then
  // out_valid stays high and result/branch_sel/illegal do not change.

  localparam int SHW = $clog2(XLEN);

  op_e             op_dec;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, add_sum;
  branch_sel_e     alu_br;
  logic            alu_ill, is_m;

  always_comb begin
    op_dec = OP_NONE;
    if (op <= OPW'(OP_M_LAST)) op_dec = op_e'(op[5:0]);
  end

  assign shamt   = src_b[SHW-1:0];
  assign add_sum = src_a + src_b;

  always_comb begin
    alu_res = '0;
    alu_br  = BR_NONE;
    alu_ill = 1'b0;
    is_m    = 1'b0;
    case (op_dec)
      OP_ADD, OP_ADDI:   alu_res = add_sum;
      OP_SUB:            alu_res = src_a - src_b;
      OP_AND, OP_ANDI:   alu_res = src_a & src_b;
      OP_OR, OP_ORI:     alu_res = src_a | src_b;
      OP_XOR, OP_XORI:   alu_res = src_a ^ src_b;
      OP_SLT, OP_SLTI:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU, OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SRA, OP_SRAI:   alu_res = $signed(src_a) >>> shamt;
      OP_SRL, OP_SRLI:   alu_res = src_a >> shamt;
      OP_SLL, OP_SLLI:   alu_res = src_a << shamt;
      OP_LUI:            alu_res = src_b;  // immediate arrives pre-shifted
      OP_LW, OP_SW:      alu_res = {add_sum[XLEN-1:2], 2'b00};
      OP_BEQ:            alu_br  = (src_a == src_b) ? BR_TAKEN : BR_NOT_TAKEN;
      OP_BNE:            alu_br  = (src_a != src_b) ? BR_TAKEN : BR_NOT_TAKEN;
      OP_BLT:            alu_br  = ($signed(src_a) < $signed(src_b)) ? BR_TAKEN : BR_NOT_TAKEN;
      OP_BGT:            alu_br  = ($signed(src_a) > $signed(src_b)) ? BR_TAKEN : BR_NOT_TAKEN;
      OP_BLTU:           alu_br  = (src_a < src_b) ? BR_TAKEN : BR_NOT_TAKEN;
      OP_BGEU:           alu_br  = (src_a >= src_b) ? BR_TAKEN : BR_NOT_TAKEN;
      OP_AUIPC:          alu_br  = BR_NOT_TAKEN;
      OP_JAL, OP_JALR:   alu_br  = BR_TAKEN;
`ifdef ALU_MDU_M_EN
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_m = 1'b1;
`endif
      default:           alu_ill = 1'b1;
    endcase
  end

  state_e         state_q, state_d;
  logic [SHW-1:0] cnt_q;
  logic           accept;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = is_m ? S_BUSY : S_DONE;
      end
      S_BUSY: if (cnt_q == SHW'(XLEN-1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [XLEN-1:0] result_q;
  branch_sel_e     br_q;
  logic            ill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      br_q     <= BR_NONE;
      ill_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_BUSY) ? cnt_q + SHW'(1) : '0;
      if (accept) begin
        result_q <= alu_res;
        br_q     <= alu_br;
        ill_q    <= alu_ill;
      end
    end
  end

`ifdef ALU_MDU_M_EN
  logic [XLEN-1:0] m_res;
  logic            is_m_q;

  alu_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (accept & is_m),
    .step  (state_q == S_BUSY),
    .sel   (op[2:0]),
    .a     (src_a),
    .b     (src_b),
    .res   (m_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         is_m_q <= 1'b0;
    else if (accept) is_m_q <= is_m;
  end

  assign result = is_m_q ? m_res : result_q;
`else
  assign result = result_q;
`endif

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign branch_sel = br_q;
  assign illegal    = ill_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Bench for alu_mdu_unit: directed corner cases and randomized ops checked against a
// plain-arithmetic reference model. Ops 32-39 are expected to work only with ALU_MDU_M_EN.
module tb_alu_mdu_unit;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, illegal;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] src_a, src_b, result;
  logic [1:0]      branch_sel;
  state_e          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_mdu_unit #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .branch_sel (branch_sel),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: result, branch select, illegal flag and cycles to out_valid
  function automatic void ref_model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [1:0] br,
                                    output logic ill, output int lat);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    int              sh;
    bit              div_ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    sh = int'(b[4:0]);
    div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; br = 2'b00; ill = 1'b0; lat = 1;
    case (o)
      1, 11:  r = a + b;
      2:      r = a - b;
      3, 12:  r = a & b;
      4, 13:  r = a | b;
      5, 14:  r = a ^ b;
      6, 15:  r = (sa < sb) ? 32'd1 : 32'd0;
      7, 16:  r = (a < b) ? 32'd1 : 32'd0;
      8, 17:  begin p = sa >>> sh; r = p[31:0]; end
      9, 18:  r = a >> sh;
      10, 19: r = a << sh;
      20:     r = b;
      21, 22: r = (a + b) & 32'hFFFF_FFFC;
      23:     br = (a == b) ? 2'b10 : 2'b01;
      24:     br = (a != b) ? 2'b10 : 2'b01;
      25:     br = (sa < sb) ? 2'b10 : 2'b01;
      26:     br = (sa > sb) ? 2'b10 : 2'b01;
      27:     br = (a < b) ? 2'b10 : 2'b01;
      28:     br = (a >= b) ? 2'b10 : 2'b01;
      29:     br = 2'b01;
      30, 31: br = 2'b10;
`ifdef ALU_MDU_M_EN
      32:     begin p = sa * sb; r = p[31:0]; lat = XLEN + 1; end
      33:     begin p = sa * sb; r = p[63:32]; lat = XLEN + 1; end
      34:     begin p = sa * longint'(ub); r = p[63:32]; lat = XLEN + 1; end
      35:     begin up = ua * ub; r = up[63:32]; lat = XLEN + 1; end
      36:     begin
        lat = XLEN + 1;
        if (b == 0) r = '1;
        else if (div_ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      37:     begin lat = XLEN + 1; if (b == 0) r = '1; else r = a / b; end
      38:     begin
        lat = XLEN + 1;
        if (b == 0) r = a;
        else if (div_ovf) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      39:     begin lat = XLEN + 1; if (b == 0) r = a; else r = a % b; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver + scoreboard: issue one op from IDLE at a negedge, hold off out_ready for
  // `hold` cycles of DONE, and finish at a negedge with the unit back in IDLE
  task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic [1:0]  eb;
    logic        ei;
    int          el, lat;
    ref_model(o, a, b, er, eb, ei, el);
    exp_q.push_back(er);
    check_eq("idle_ready", in_ready, 1);
    out_ready = (hold == 0);
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    in_valid = 1'b0; op = 6'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    er = exp_q.pop_front();
    check_eq("latency", lat, el);
    if (!out_valid) begin
      apply_reset();
      out_ready = 1'b1;
      return;
    end
    check_eq("result", result, er);
    check_eq("branch_sel", branch_sel, eb);
    check_eq("illegal", illegal, ei);
    check_eq("busy_not_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("held_valid", out_valid, 1);
      check_eq("held_result", result, er);
      check_eq("held_not_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("back_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_branch_sel", branch_sel, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // directed corners
    run_op(6'd1,  32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(6'd25, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(6'd27, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(6'd36, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(6'd37, 32'h0000_0007, 32'h0000_0000, 0);
    run_op(6'd38, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(6'd33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(6'd35, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(6'd34, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(6'd8,  32'h8000_00F0, 32'hFFFF_FFE4, 0);
    run_op(6'd21, 32'h0000_1003, 32'h0000_0002, 0);
    run_op(6'd30, 32'h1234_5678, 32'h0000_0004, 0);
    run_op(6'd2,  32'h0000_0005, 32'h0000_0006, 5);
    run_op(6'd36, 32'hFFFF_FF9C, 32'h0000_0007, 5);
    run_op(6'd45, 32'h0000_0001, 32'h0000_0002, 0);
    run_op(6'd0,  32'h0000_0003, 32'h0000_0004, 0);

    // reset while an op is in flight: DIV in BUSY, or an op held in DONE without the M unit
    out_ready = 1'b0;
    in_valid = 1'b1; op = 6'd36; src_a = $urandom; src_b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`ifdef ALU_MDU_M_EN
    check_eq("pre_rst_state", dbg_state, S_BUSY);
`else
    check_eq("pre_rst_state", dbg_state, S_DONE);
`endif
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_result", result, 0);
    check_eq("mid_rst_branch_sel", branch_sel, 0);
    check_eq("mid_rst_illegal", illegal, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    check_eq("no_stale_output", seen, 0);

    // randomized ops
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o;
      int hold;
      o = 6'($urandom_range(0, 47));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(o, pick_val(), pick_val(), hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_unit.md
ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width in bits (legal values 32 and 64).
REQ-002 The block SHALL have parameter OPW, default 6, meaning opcode width.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock.
REQ-004 The port rst SHALL be an input, 1 bit wide: the reset, which is asynchronous and active-high.
REQ-005 The port in_valid SHALL be an input, 1 bit wide: the operation request.
REQ-006 The port in_ready SHALL be an output, 1 bit wide: the unit can accept an operation.
REQ-007 The port op SHALL be an input, OPW bits wide: the operation code.
REQ-008 The ports src_a and src_b SHALL be inputs, each XLEN bits wide: the operands (rs1 and rs2/imm).
REQ-009 The port out_valid SHALL be an output, 1 bit wide: a result is presented.
REQ-010 The port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-011 The port result SHALL be an output, XLEN bits wide: the ALU/MDU result.
REQ-012 The port branch_sel SHALL be an output, 2 bits wide, encoded as follows.
- 00: not a branch.
- 01: not taken, or sequential.
- 10: taken.
REQ-013 The port illegal SHALL be an output, 1 bit wide: the accepted op was unsupported.

Function
REQ-014 Op codes 1-31 SHALL keep the existing ALU encoding and semantics.
- 1-20: ADD, SUB, AND, OR, XOR, SLT, SLTU, SRA, SRL, SLL, then the I-variants, then LUI.
- 21-22: LW/SW address add with result[1:0] forced to 0.
- 23-28: BEQ, BNE, BLT, BGT (signed >), BLTU, BGEU.
- 29-31: AUIPC (branch_sel 01), JAL and JALR (branch_sel 10).
REQ-015 Shift amounts SHALL use src_b[$clog2(XLEN)-1:0].
REQ-016 All arithmetic SHALL be XLEN-bit modulo.
REQ-017 Op codes 32-39 SHALL be MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with RISC-V M semantics at XLEN.
REQ-018 Op code 0 and codes 40 and above SHALL complete in 1 cycle with result=0, branch_sel=00, illegal=1.
REQ-019 Branch, AUIPC and JAL/JALR ops SHALL return result=0; all non-branch ops SHALL return branch_sel=00.
REQ-020 The FSM SHALL have the states IDLE, BUSY and DONE, with in_ready=1 only in IDLE.
REQ-021 An operation SHALL be accepted on a clk edge with in_valid&in_ready.
- A single-cycle op moves IDLE->DONE.
- Ops 32-39 move IDLE->BUSY.
REQ-022 In BUSY, an iteration counter SHALL count XLEN cycles, then the FSM moves to DONE, so out_valid rises XLEN+1 cycles after acceptance.
REQ-023 In DONE, out_valid SHALL be 1 and result, branch_sel and illegal SHALL be held stable until out_valid&out_ready, then the FSM moves to IDLE.
REQ-024 Back-to-back throughput for single-cycle ops SHALL be one op per 2 cycles; operands SHALL be registered at acceptance, so input changes after acceptance have no effect.
REQ-025 Divide by zero SHALL give quotient all-ones and remainder = dividend.
REQ-026 Signed overflow (MIN / -1) SHALL give quotient MIN and remainder 0.
REQ-027 Signed MUL/DIV ops SHALL use magnitude iteration with a final sign fix-up within the XLEN count.
REQ-028 in_valid while not IDLE SHALL be ignored, with no queueing.

Reset
REQ-029 Asserting rst SHALL asynchronously force the following, at any time including mid-BUSY:
- state=IDLE and counter=0;
- out_valid=0, result=0, branch_sel=00, illegal=0.
REQ-030 Following a rst assertion, in_ready SHALL be 1; an in-flight operation SHALL be discarded without output.

Configuration
REQ-031 With ALU_MDU_M_EN defined, ops 32-39 SHALL be implemented per REQ-017 and REQ-022.
REQ-032 With ALU_MDU_M_EN undefined, ops 32-39 SHALL be treated as illegal per REQ-018, with no BUSY entry and no mul/div hardware instantiated.

Structure
REQ-033 Package alu_pkg SHALL hold the following:
- the op_e enum (codes 0-39);
- the branch_sel_e typedef;
- the state_e enum;
- constants OP_M_FIRST=32 and OP_M_LAST=39.
REQ-034 The iterative shift-add multiplier / restoring divider SHALL be the sub-module alu_mdu_iter, instantiated only under ALU_MDU_M_EN.

Verification
REQ-035 The bench SHALL run ADD 0x7FFFFFFF+1 with out_ready=1: out_valid 1 cycle after acceptance, result=0x80000000, branch_sel=00.
REQ-036 The bench SHALL run BLT src_a=0xFFFFFFFF, src_b=1: branch_sel=10; BLTU on the same operands: branch_sel=01.
REQ-037 The bench SHALL run DIV 0x80000000 / 0xFFFFFFFF: out_valid at cycle 33 after acceptance, result=0x80000000; DIVU 7/0: result=0xFFFFFFFF.
REQ-038 The bench SHALL run MULH 0xFFFFFFFF x 0xFFFFFFFF: result=0; MULHU on the same operands: result=0xFFFFFFFE.
REQ-039 The bench SHALL run out_ready=0 for 5 cycles after DONE: result held stable, in_ready=0; out_ready=1: IDLE next cycle.
REQ-040 The bench SHALL assert rst at BUSY cycle 10 of a DIV: out_valid stays 0 and in_ready=1 after reset. Separately, op=45 SHALL give illegal=1 and result=0.
